// File: rtl/fir_coeff_loader.sv
// Coefficient bank loader for the FIR: serial beats fill a shadow bank, and a
// correctly framed load is copied to the active bank in one edge when swap_en allows.
module fir_coeff_loader #(
   parameter int BITWIDTH = 16,
   parameter int N        = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [BITWIDTH-1:0]   s_data,
   input  logic                  s_last,
   input  logic                  swap_en,
   output logic [BITWIDTH*N-1:0] coeffs,
   output logic                  coeff_update,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

   state_t              state;
   state_t              state_next;
   logic [IW-1:0]       idx;
   logic [BITWIDTH-1:0] shadow [N];
   logic [BITWIDTH-1:0] active [N];
   logic                pulse;
   logic                xfer;
   logic                at_last_tap;

   assign xfer        = s_valid && s_ready;
   assign at_last_tap = (idx == IW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD: begin
            if (xfer) begin
               if (s_last)           state_next = at_last_tap ? COMMIT : IDLE;
               else if (at_last_tap) state_next = DRAIN;
            end
         end
         DRAIN:   if (xfer && s_last) state_next = IDLE;
         COMMIT:  if (swap_en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // s_ready depends only on the registered state, so it never follows s_valid combinationally.
   always_comb begin
      s_ready      = (state == LOAD) || (state == DRAIN);
      busy         = (state != IDLE);
      coeff_update = pulse;
      done         = pulse;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         err   <= 1'b0;
         pulse <= 1'b0;
         for (int i = 0; i < N; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         pulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  idx <= '0;
                  err <= 1'b0;
               end
            end
            LOAD: begin
               if (xfer) begin
                  shadow[idx] <= s_data;
                  idx         <= idx + IW'(1);
                  if (s_last && !at_last_tap) err <= 1'b1;
               end
            end
            DRAIN: begin
               if (xfer && s_last) err <= 1'b1;
            end
            COMMIT: begin
               // Whole bank moves on one edge so the filter never sees a partial set.
               if (swap_en) begin
                  for (int i = 0; i < N; i++) active[i] <= shadow[i];
                  pulse <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign coeffs[BITWIDTH*g +: BITWIDTH] = active[g];
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomised bench for fir_coeff_loader: frames are judged by length and last-beat
// position against a reference bank, with commit timing and atomicity checked per cycle.
module tb_fir_coeff_loader;

   localparam int BITWIDTH = 16;
   localparam int N        = 16;
   localparam int W        = BITWIDTH * N;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                s_valid = 1'b0;
   logic                s_last = 1'b0;
   logic                swap_en = 1'b0;
   logic [BITWIDTH-1:0] s_data = '0;
   logic                s_ready;
   logic [W-1:0]        coeffs;
   logic                coeff_update;
   logic                busy;
   logic                done;
   logic                err;

   int total = 0;
   int bad   = 0;

   logic [BITWIDTH-1:0] ref_bank [N];
   logic [BITWIDTH-1:0] frame [$];

   fir_coeff_loader #(.BITWIDTH(BITWIDTH), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .swap_en(swap_en), .coeffs(coeffs),
      .coeff_update(coeff_update), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_coeffs();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[BITWIDTH*i +: BITWIDTH] = ref_bank[i];
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A frame commits only when it holds exactly N beats with s_last on the last one.
   task automatic applyStimulus(input int last_at, input bit gaps, input int swap_wait, input bit start_noise);
      int  nbeats;
      bit  good;
      nbeats = frame.size();
      good   = (nbeats == N) && (last_at == N - 1);
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("busy_after_start", W'(busy), W'(1));
      checkOutput("err_cleared_by_start", W'(err), W'(0));
      for (int b = 0; b < nbeats; b++) begin
         if (gaps && (b % 2 == 1)) begin
            s_valid = 1'b0;
            step();
         end
         s_valid = 1'b1;
         s_data  = frame[b];
         s_last  = (b == last_at);
         start   = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         checkOutput("s_ready_beat", W'(s_ready), W'(1));
         checkOutput("coeffs_hold_load", coeffs, ref_coeffs());
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      start   = 1'b0;
      if (good) begin
         for (int w = 0; w <= swap_wait; w++) begin
            checkOutput("coeffs_hold_wait", coeffs, ref_coeffs());
            checkOutput("no_update_wait", W'(coeff_update), W'(0));
            checkOutput("busy_wait", W'(busy), W'(1));
            checkOutput("s_ready_commit", W'(s_ready), W'(0));
            if (w == swap_wait) swap_en = 1'b1;
            step();
         end
         swap_en = 1'b0;
         for (int i = 0; i < N; i++) ref_bank[i] = frame[i];
         checkOutput("coeffs_new", coeffs, ref_coeffs());
         checkOutput("coeff_update_pulse", W'(coeff_update), W'(1));
         checkOutput("done_pulse", W'(done), W'(1));
         checkOutput("busy_after_commit", W'(busy), W'(0));
         checkOutput("err_after_commit", W'(err), W'(0));
         step();
         checkOutput("coeff_update_one_cycle", W'(coeff_update), W'(0));
         checkOutput("done_one_cycle", W'(done), W'(0));
      end else begin
         for (int w = 0; w < 2; w++) begin
            checkOutput("err_frame", W'(err), W'(1));
            checkOutput("busy_after_err", W'(busy), W'(0));
            checkOutput("s_ready_after_err", W'(s_ready), W'(0));
            checkOutput("coeffs_unchanged_err", coeffs, ref_coeffs());
            checkOutput("no_update_err", W'(coeff_update), W'(0));
            step();
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) ref_bank[i] = '0;

      step();
      checkOutput("reset_coeffs", coeffs, '0);
      checkOutput("reset_s_ready", W'(s_ready), W'(0));
      checkOutput("reset_busy", W'(busy), W'(0));
      checkOutput("reset_err", W'(err), W'(0));
      rst_n = 1'b1;

      // Beats offered in IDLE must not be accepted.
      for (int c = 0; c < 5; c++) begin
         s_valid = 1'b1;
         s_data  = BITWIDTH'($urandom);
         step();
         checkOutput("idle_coeffs", coeffs, '0);
         checkOutput("idle_s_ready", W'(s_ready), W'(0));
         checkOutput("idle_busy", W'(busy), W'(0));
         checkOutput("idle_no_update", W'(coeff_update), W'(0));
      end
      s_valid = 1'b0;

      frame.delete();
      for (int i = 0; i < N; i++) frame.push_back(BITWIDTH'(i));
      applyStimulus(N - 1, 1'b0, 0, 1'b0);

      frame.delete();
      for (int i = 0; i < N; i++) frame.push_back(BITWIDTH'(-(i + 1)));
      applyStimulus(N - 1, 1'b1, 7, 1'b0);

      frame.delete();
      for (int i = 0; i < 10; i++) frame.push_back(BITWIDTH'($urandom));
      applyStimulus(9, 1'b0, 0, 1'b0);

      frame.delete();
      for (int i = 0; i < 20; i++) frame.push_back(BITWIDTH'($urandom));
      applyStimulus(19, 1'b0, 0, 1'b1);

      for (int r = 0; r < 6; r++) begin
         int len;
         len = (r % 3 == 0) ? N : int'($urandom_range(2, N + 4));
         frame.delete();
         for (int i = 0; i < len; i++) frame.push_back(BITWIDTH'($urandom));
         applyStimulus(len - 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
      end

      frame.delete();
      for (int i = 0; i < N; i++) frame.push_back(BITWIDTH'($urandom_range(1, 65535)));
      applyStimulus(N - 1, 1'b0, 1, 1'b0);
      checkOutput("nonzero_before_abort", W'(coeffs != '0), W'(1));

      start = 1'b1;
      step();
      start = 1'b0;
      for (int b = 0; b < 7; b++) begin
         s_valid = 1'b1;
         s_data  = BITWIDTH'($urandom);
         s_last  = 1'b0;
         step();
      end
      s_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      for (int i = 0; i < N; i++) ref_bank[i] = '0;
      checkOutput("abort_coeffs", coeffs, ref_coeffs());
      checkOutput("abort_s_ready", W'(s_ready), W'(0));
      checkOutput("abort_busy", W'(busy), W'(0));
      checkOutput("abort_err", W'(err), W'(0));
      checkOutput("abort_update", W'(coeff_update), W'(0));
      step();
      rst_n = 1'b1;
      step();
      checkOutput("post_abort_busy", W'(busy), W'(0));
      checkOutput("post_abort_coeffs", coeffs, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
